// File: rtl/scr_status_pulse_encoder.sv
// scr_status_pulse_encoder: queues SCR status events and sends them as width-coded pulses by priority
module scr_status_pulse_encoder #(
  parameter int CNT_W  = 6,
  parameter int W_FWD  = 8,
  parameter int W_NEG  = 16,
  parameter int W_FBOD = 32,
  parameter int W_NBOD = 48,
  parameter int GAP    = 16
) (
  input  logic       i_clk_50m,
  input  logic       i_rst_n,
  input  logic       i_forward_state,
  input  logic       i_negative_state,
  input  logic       i_forward_bod,
  input  logic       i_negative_bod,
  input  logic       i_signal_forbid,
  output logic       o_signal,
  output logic       o_busy,
  output logic [3:0] o_pending,
  output logic       o_overflow
);
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_PULSE = 2'd1, S_GAP = 2'd2;

  generate
    if (W_FWD < 1 || W_FWD > CMAX || W_NEG < 1 || W_NEG > CMAX || W_FBOD < 1 || W_FBOD > CMAX ||
        W_NBOD < 1 || W_NBOD > CMAX || GAP < 1 || GAP > CMAX) begin : g_bad_param
      $error("scr_status_pulse_encoder: width parameter outside 1..2^CNT_W-1");
    end
  endgenerate

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt, w_sel;
  logic [3:0]       cur, prev, ev, sel, clr;
  logic             start;

  assign cur = {i_negative_bod, i_forward_bod, i_negative_state, i_forward_state};
  assign ev  = cur & ~prev;

  always_comb begin
    sel   = o_pending[3] ? 4'b1000 : o_pending[2] ? 4'b0100 : o_pending[1] ? 4'b0010 :
            o_pending[0] ? 4'b0001 : 4'b0000;
    w_sel = o_pending[3] ? CNT_W'(W_NBOD - 1) : o_pending[2] ? CNT_W'(W_FBOD - 1) :
            o_pending[1] ? CNT_W'(W_NEG - 1) : CNT_W'(W_FWD - 1);
    start = |o_pending && !i_signal_forbid && (state == S_IDLE || (state == S_GAP && cnt == '0));
    clr   = start ? sel : 4'b0000;
  end

  // a new event on a bit being cleared this cycle re-queues it rather than overflowing
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      prev       <= cur;
      o_pending  <= 4'b0000;
      o_overflow <= 1'b0;
    end else begin
      prev       <= cur;
      o_pending  <= (o_pending & ~clr) | ev;
      o_overflow <= o_overflow | |(ev & o_pending & ~clr);
      if (start) begin
        state <= S_PULSE;
        cnt   <= w_sel;
      end else if (state == S_PULSE) begin
        state <= cnt == '0 ? S_GAP : S_PULSE;
        cnt   <= cnt == '0 ? CNT_W'(GAP - 1) : cnt - 1'b1;
      end else if (state == S_GAP) begin
        state <= cnt == '0 ? S_IDLE : S_GAP;
        cnt   <= cnt == '0 ? '0 : cnt - 1'b1;
      end else begin
        state <= S_IDLE;
        cnt   <= '0;
      end
    end
  end

  assign o_signal = state == S_PULSE;
  assign o_busy   = state != S_IDLE;
endmodule
